// File: rtl/cu_wgt_pkg.sv
// Shared types and defaults for the compute-unit weight loader.
// Load sequencer states, default geometry, and a saturating increment helper.
package cu_wgt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } wgt_state_e;

    localparam int WGT_DW     = 8;
    localparam int WGT_NUM_PE = 9;
    localparam int WGT_KCNT_W = 8;
    localparam int STALL_W    = 16;

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (&v) ? v : v + STALL_W'(1);
    endfunction

endpackage

// File: rtl/wgt_sel_dec.sv
// PE select decoder: turns a PE index plus enable into a one-hot strobe vector.
module wgt_sel_dec
    import cu_wgt_pkg::*;
#(
    parameter int NUM_PE = WGT_NUM_PE,
    parameter int IDX_W  = $clog2(NUM_PE)
) (
    input  logic [IDX_W-1:0]  idx,
    input  logic              en,
    output logic [NUM_PE-1:0] sel
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PE; gi++) begin : g_sel
            assign sel[gi] = en && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/wgt_load_ctrl.sv
// Weight load sequencer for one compute unit: streams NUM_PE weights per kernel
// into the rf_wgt registers, holds while the array computes, repeats per kernel.
// Optional stall counter is built when WGT_STALL_CNT_EN is defined.
module wgt_load_ctrl
    import cu_wgt_pkg::*;
#(
    parameter int NUM_PE = WGT_NUM_PE,
    parameter int DW     = WGT_DW,
    parameter int KCNT_W = WGT_KCNT_W
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [KCNT_W-1:0]    cfg_num_kern,
    input  logic                 wgt_in_valid,
    output logic                 wgt_in_ready,
    input  logic signed [DW-1:0] wgt_in,
    output logic signed [DW-1:0] wgt_out,
    output logic [NUM_PE-1:0]    wgt_read,
    input  logic                 comp_done,
    output logic                 wgt_loaded,
    output logic                 busy,
    output logic                 done
`ifdef WGT_STALL_CNT_EN
    ,
    output logic [STALL_W-1:0]   stall_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_PE);

    wgt_state_e            state_reg, state_next;
    logic [IDX_W-1:0]      pe_idx_reg;
    logic [KCNT_W-1:0]     kern_cnt_reg;
    logic [KCNT_W-1:0]     num_kern_reg;
    logic signed [DW-1:0]  wgt_out_reg;
    logic [NUM_PE-1:0]     wgt_read_reg;
    logic                  wgt_loaded_reg;
    logic                  done_reg;
    logic                  hs;
    logic                  last_pe;
    logic                  last_kern;
    logic [NUM_PE-1:0]     sel_vec;

    assign last_pe   = (pe_idx_reg == IDX_W'(NUM_PE - 1));
    assign last_kern = (kern_cnt_reg == num_kern_reg - KCNT_W'(1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start) state_next = (cfg_num_kern == '0) ? DONE : LOAD;
            LOAD: if (hs && last_pe) state_next = HOLD;
            HOLD: if (comp_done) state_next = last_kern ? DONE : LOAD;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wgt_in_ready = (state_reg == LOAD);
        busy         = (state_reg != IDLE);
        hs           = wgt_in_valid && (state_reg == LOAD);
    end

    wgt_sel_dec #(
        .NUM_PE (NUM_PE),
        .IDX_W  (IDX_W)
    ) u_sel_dec (
        .idx (pe_idx_reg),
        .en  (hs),
        .sel (sel_vec)
    );

    // Strobe and weight are registered so rf_wgt captures on the edge after.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pe_idx_reg     <= '0;
            kern_cnt_reg   <= '0;
            num_kern_reg   <= '0;
            wgt_out_reg    <= '0;
            wgt_read_reg   <= '0;
            wgt_loaded_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            if (state_reg == IDLE && start) begin
                num_kern_reg <= cfg_num_kern;
            end
            if (hs) begin
                pe_idx_reg  <= last_pe ? '0 : pe_idx_reg + IDX_W'(1);
                wgt_out_reg <= wgt_in;
            end
            if (state_reg == HOLD && comp_done && !last_kern) begin
                kern_cnt_reg <= kern_cnt_reg + KCNT_W'(1);
            end else if (state_reg == DONE) begin
                kern_cnt_reg <= '0;
            end
            wgt_read_reg   <= sel_vec;
            // Loaded only once the final strobe has been visible for a cycle.
            wgt_loaded_reg <= (state_reg == HOLD) && (state_next == HOLD);
            done_reg       <= (state_reg == DONE);
        end
    end

    assign wgt_out    = wgt_out_reg;
    assign wgt_read   = wgt_read_reg;
    assign wgt_loaded = wgt_loaded_reg;
    assign done       = done_reg;

`ifdef WGT_STALL_CNT_EN
    logic [STALL_W-1:0] stall_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt_reg <= '0;
        end else if (state_reg == IDLE && start) begin
            stall_cnt_reg <= '0;
        end else if (state_reg == LOAD && !wgt_in_valid) begin
            stall_cnt_reg <= sat_inc(stall_cnt_reg);
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_wgt_load_ctrl.sv
// Self-checking bench for wgt_load_ctrl: directed jobs plus randomized valid and
// comp_done timing, compared every cycle against a weight/kernel counting model.
module tb_wgt_load_ctrl;

    localparam int NUM_PE = 9;
    localparam int DW     = 8;
    localparam int KCNT_W = 8;

    logic                 clk;
    logic                 rstn;
    logic                 start;
    logic [KCNT_W-1:0]    cfg_num_kern;
    logic                 wgt_in_valid;
    logic                 wgt_in_ready;
    logic signed [DW-1:0] wgt_in;
    logic signed [DW-1:0] wgt_out;
    logic [NUM_PE-1:0]    wgt_read;
    logic                 comp_done;
    logic                 wgt_loaded;
    logic                 busy;
    logic                 done;
`ifdef WGT_STALL_CNT_EN
    logic [15:0]          stall_cnt;
`endif

    wgt_load_ctrl #(
        .NUM_PE (NUM_PE),
        .DW     (DW),
        .KCNT_W (KCNT_W)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .cfg_num_kern (cfg_num_kern),
        .wgt_in_valid (wgt_in_valid),
        .wgt_in_ready (wgt_in_ready),
        .wgt_in       (wgt_in),
        .wgt_out      (wgt_out),
        .wgt_read     (wgt_read),
        .comp_done    (comp_done),
        .wgt_loaded   (wgt_loaded),
        .busy         (busy),
        .done         (done)
`ifdef WGT_STALL_CNT_EN
        ,
        .stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int fail_cnt = 0;

    // Reference model: job in terms of weights accepted and kernels completed.
    bit                   m_active;
    bit                   m_finish;
    bit                   m_done;
    int                   m_n;
    int                   m_acc;
    int                   m_kdone;
    int                   m_hold_age;
    logic [NUM_PE-1:0]    m_read;
    logic signed [DW-1:0] m_out;
    logic [15:0]          m_stall;

    int obs_rdy, obs_done, obs_rise, obs_strobes, step_idx, done_at;
    bit prev_loaded;
    int lc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready();
        return m_active && !m_finish && (m_acc < (m_kdone + 1) * NUM_PE);
    endfunction

    function automatic bit m_holding();
        return m_active && !m_finish && !m_ready();
    endfunction

    task automatic check_all();
        chk("ready",  32'(wgt_in_ready), 32'(m_ready()));
        chk("busy",   32'(busy),         32'(m_active));
        chk("loaded", 32'(wgt_loaded),   32'(m_holding() && m_hold_age >= 1));
        chk("done",   32'(done),         32'(m_done));
        chk("read",   32'(wgt_read),     32'(m_read));
        chk("wout",   32'(wgt_out),      32'(m_out));
`ifdef WGT_STALL_CNT_EN
        chk("stall",  32'(stall_cnt),    32'(m_stall));
`endif
    endtask

    task automatic clear_obs();
        obs_rdy = 0; obs_done = 0; obs_rise = 0; obs_strobes = 0;
        step_idx = 0; done_at = -1;
    endtask

    task automatic step(input bit s, input logic [KCNT_W-1:0] k, input bit v,
                        input logic signed [DW-1:0] w, input bit c);
        bit r_pre, fin_pre;
        r_pre   = m_ready();
        fin_pre = m_finish;
        start = s; cfg_num_kern = k; wgt_in_valid = v; wgt_in = w; comp_done = c;
        @(posedge clk);
        #1;
        m_done = fin_pre;
        m_read = '0;
        if (r_pre && v) begin
            m_read[m_acc % NUM_PE] = 1'b1;
            m_out = w;
        end
        if (r_pre && !v && m_stall != 16'hFFFF) m_stall++;
        if (!m_active) begin
            if (s) begin
                m_active = 1; m_n = int'(k); m_acc = 0; m_kdone = 0;
                m_hold_age = 0; m_stall = '0; m_finish = (k == '0);
            end
        end else if (fin_pre) begin
            m_active = 0; m_finish = 0;
        end else if (r_pre) begin
            if (v) m_acc++;
            m_hold_age = 0;
        end else if (c) begin
            m_kdone++;
            m_hold_age = 0;
            if (m_kdone == m_n) m_finish = 1;
        end else begin
            m_hold_age++;
        end
        start = 0; comp_done = 0;
        check_all();
        step_idx++;
        obs_rdy     += int'(wgt_in_ready);
        obs_done    += int'(done);
        obs_rise    += int'(wgt_loaded && !prev_loaded);
        obs_strobes += int'(wgt_read != '0);
        if (done && done_at < 0) done_at = step_idx;
        prev_loaded = wgt_loaded;
    endtask

    // mode 0: valid always 1, weights -1..-9; 1: valid toggles 0/1 per LOAD cycle;
    // 2: random valid and hold length; 3: as 2 plus stray start/comp_done in LOAD.
    task automatic pick_and_step(input int mode);
        bit v, s, c;
        logic signed [DW-1:0] w;
        s = 0; c = 0;
        case (mode)
            0: v = 1;
            1: begin
                if (m_ready()) begin v = lc[0]; lc++; end
                else begin v = 0; lc = 0; end
            end
            default: v = bit'($urandom_range(0, 1));
        endcase
        w = (mode == 0) ? DW'(-((m_acc % NUM_PE) + 1)) : DW'($urandom);
        if (m_holding()) begin
            c = (mode < 2) ? (m_hold_age >= 2) : ($urandom_range(0, 3) == 0);
        end
        if (mode == 3 && m_ready()) begin
            s = bit'($urandom_range(0, 1));
            c = bit'($urandom_range(0, 1));
        end
        step(s, KCNT_W'($urandom), v, w, c);
    endtask

    task automatic run_job(input int k, input int mode);
        int guard;
        guard = 0;
        lc = 0;
        step(1, KCNT_W'(k), 0, '0, 0);
        while ((m_active || m_done) && guard < 3000) begin
            pick_and_step(mode);
            guard++;
        end
        chk("job_bound", 32'(guard < 3000), 32'd1);
    endtask

    task automatic do_reset(input int n);
        rstn = 0; wgt_in_valid = 1; start = 0; comp_done = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            m_active = 0; m_finish = 0; m_done = 0; m_acc = 0; m_kdone = 0;
            m_hold_age = 0; m_read = '0; m_out = '0; m_stall = '0;
            check_all();
        end
        rstn = 1; wgt_in_valid = 0;
        prev_loaded = 0;
    endtask

    initial begin
        rstn = 0; start = 0; cfg_num_kern = '0; wgt_in_valid = 0; wgt_in = '0;
        comp_done = 0; prev_loaded = 0; lc = 0;
        clear_obs();
        do_reset(2);

        // Single kernel, continuous valid, weights -1..-9.
        clear_obs();
        run_job(1, 0);
        chk("a_strobes", 32'(obs_strobes), 32'd9);
        chk("a_loaded",  32'(obs_rise),    32'd1);
        chk("a_done",    32'(obs_done),    32'd1);

        // Three kernels with valid toggling: 18 LOAD cycles each.
        clear_obs();
        run_job(3, 1);
        chk("b_ready_cyc", 32'(obs_rdy),  32'd54);
        chk("b_holds",     32'(obs_rise), 32'd3);
        chk("b_done",      32'(obs_done), 32'd1);
`ifdef WGT_STALL_CNT_EN
        chk("b_stall", 32'(stall_cnt), 32'd27);
`endif

        // Zero kernels: straight to done.
        clear_obs();
        run_job(0, 0);
        chk("c_done_lat", 32'(done_at),     32'd2);
        chk("c_strobes",  32'(obs_strobes), 32'd0);
        chk("c_ready",    32'(obs_rdy),     32'd0);

        // Stray start/comp_done during LOAD must not disturb the sequence.
        clear_obs();
        run_job(2, 3);
        chk("d_strobes", 32'(obs_strobes), 32'd18);
        chk("d_done",    32'(obs_done),    32'd1);

        // Reset for 3 cycles in the middle of LOAD, then a fresh job.
        clear_obs();
        step(1, KCNT_W'(2), 0, '0, 0);
        repeat (5) pick_and_step(2);
        do_reset(3);
        clear_obs();
        run_job(2, 0);
        chk("e_strobes", 32'(obs_strobes), 32'd18);
        chk("e_done",    32'(obs_done),    32'd1);

        // Randomized jobs.
        for (int j = 0; j < 4; j++) begin
            int k;
            k = int'($urandom_range(1, 3));
            clear_obs();
            run_job(k, 2);
            chk("r_strobes", 32'(obs_strobes), 32'(k * NUM_PE));
            chk("r_done",    32'(obs_done),    32'd1);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
